// File: rtl/channel_rr_arbiter.sv
// M-way round-robin arbiter with burst locking: shares one valid/ack output
// channel among M requesters, holding a grant for up to MaxBurst transfers.
module channel_rr_arbiter #(
    parameter int N        = 8,
    parameter int M        = 4,
    parameter int MaxBurst = 4,
    parameter int SelW     = $clog2(M)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [M*N-1:0]    in_d,
    input  logic [M-1:0]      in_v,
    output logic [M-1:0]      in_a,
    input  logic [M-1:0]      en,
    output logic [N-1:0]      out_d,
    output logic              out_v,
    input  logic              out_a,
    output logic [SelW-1:0]   sel,
    output logic              locked
);

    localparam int CntW = $clog2(MaxBurst + 1);

    logic [SelW-1:0] ptr_q, ptr_d;
    logic [SelW-1:0] g_q, g_d;
    logic [SelW-1:0] sel_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            locked_q, locked_d;

    logic [M-1:0]    req_s;
    logic            hold_s;
    logic [SelW-1:0] pick_s;
    logic            found_s;
    logic [SelW-1:0] sel_s;
    logic            xfer_s;

    // Increment an index modulo M so non-power-of-2 M never yields index >= M.
    function automatic logic [SelW-1:0] wrap_inc(input logic [SelW-1:0] x);
        return (x == SelW'(M - 1)) ? '0 : x + SelW'(1);
    endfunction

    assign req_s  = in_v & en;
    assign hold_s = locked_q & req_s[g_q];

    // Round-robin scan starting at ptr; first requester found wins.
    always_comb begin
        logic [SelW:0] idx_v;
        pick_s  = sel_q;
        found_s = 1'b0;
        for (int k = 0; k < M; k++) begin
            idx_v = {1'b0, ptr_q} + (SelW+1)'(k);
            idx_v = (idx_v >= (SelW+1)'(M)) ? idx_v - (SelW+1)'(M) : idx_v;
            if (!found_s && req_s[idx_v[SelW-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_v[SelW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // A held burst overrides the scan; with no request, sel keeps its last value.
    assign sel_s  = hold_s ? g_q : (found_s ? pick_s : sel_q);
    assign out_v  = ~reset & (|req_s);
    assign xfer_s = out_v & out_a;
    assign in_a   = xfer_s ? (M'(1) << sel_s) : '0;
    assign out_d  = in_d[sel_s*N +: N];
    assign sel    = sel_s;
    assign locked = locked_q;

    // Burst/round-robin next-state; a new-grant transfer beats a lock break.
    always_comb begin
        ptr_d    = ptr_q;
        g_d      = g_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (hold_s) begin
            if (xfer_s && (cnt_q == CntW'(MaxBurst - 1))) begin
                locked_d = 1'b0;
                cnt_d    = '0;
                ptr_d    = wrap_inc(g_q);
            end else if (xfer_s) begin
                cnt_d    = cnt_q + CntW'(1);
            end else begin
                cnt_d    = cnt_q;
            end
        end else if (xfer_s) begin
            if (MaxBurst > 1) begin
                g_d      = sel_s;
                cnt_d    = CntW'(1);
                locked_d = 1'b1;
            end else begin
                locked_d = 1'b0;
                cnt_d    = '0;
                ptr_d    = wrap_inc(sel_s);
            end
        end else if (locked_q) begin
            locked_d = 1'b0;
            cnt_d    = '0;
            ptr_d    = wrap_inc(g_q);
        end else begin
            locked_d = locked_q;
        end
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            g_q      <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            g_q      <= g_d;
            sel_q    <= sel_s;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

endmodule

// File: tb/tb_channel_rr_arbiter.sv
// Table-driven bench for channel_rr_arbiter (M=4, MaxBurst=3): one record per
// cycle, state carries from record to record.
module tb_channel_rr_arbiter;

    localparam int N = 8;
    localparam int M = 4;
    localparam int MB = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [M*N-1:0]  in_d = '0;
    logic [M-1:0]    in_v = '0;
    logic [M-1:0]    in_a;
    logic [M-1:0]    en = '0;
    logic [N-1:0]    out_d;
    logic            out_v;
    logic            out_a = 1'b0;
    logic [SW-1:0]   sel;
    logic            locked;

    typedef struct {
        bit         rst;
        logic [3:0] v;
        logic [3:0] e;
        bit         a;
        int         sel;
        bit         ov;
        logic [3:0] ia;
        bit         lk;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nerr = 0;

    channel_rr_arbiter #(.N(N), .M(M), .MaxBurst(MB), .SelW(SW)) dut (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
        .en(en), .out_d(out_d), .out_v(out_v), .out_a(out_a),
        .sel(sel), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic void add(bit rst, logic [3:0] v, logic [3:0] e, bit a,
                                int s, bit ov, logic [3:0] ia, bit lk);
        vec_t t;
        t.rst = rst; t.v = v; t.e = e; t.a = a;
        t.sel = s; t.ov = ov; t.ia = ia; t.lk = lk;
        vq.push_back(t);
    endfunction

    function automatic logic [7:0] dat(int ch, int k);
        return 8'((ch + 1) * 16 + (k % 16));
    endfunction

    initial begin
        int bursts_e[5];
        logic [3:0] en_e;
        logic [7:0] exp_d;

        // reset held with requests present
        add(1'b1, 4'hF, 4'hF, 1'b1, 0, 1'b0, 4'h0, 1'b0);
        add(1'b1, 4'hF, 4'hF, 1'b1, 0, 1'b0, 4'h0, 1'b0);
        // fairness: all requesting, 3 per grant in order 0..3
        for (int c = 0; c < 24; c++)
            add(1'b0, 4'hF, 4'hF, 1'b1, (c / 3) % 4, 1'b1, 4'(1 << ((c / 3) % 4)), (c % 3) != 0);
        // lone requester 2: back-to-back, regranted every 3
        for (int c = 0; c < 10; c++)
            add(1'b0, 4'b0100, 4'hF, 1'b1, 2, 1'b1, 4'b0100, (c % 3) != 0);
        // idle with lock held: sel holds, lock breaks (ptr -> 3)
        add(1'b0, 4'b0000, 4'hF, 1'b1, 2, 1'b0, 4'h0, 1'b1);
        // grant 1, then 1 drops while 0 and 3 request
        add(1'b0, 4'b0010, 4'hF, 1'b1, 1, 1'b1, 4'b0010, 1'b0);
        add(1'b0, 4'b1001, 4'hF, 1'b0, 3, 1'b1, 4'h0, 1'b1);
        add(1'b0, 4'b0101, 4'hF, 1'b0, 2, 1'b1, 4'h0, 1'b0);
        add(1'b0, 4'b1001, 4'hF, 1'b1, 3, 1'b1, 4'b1000, 1'b0);
        add(1'b0, 4'b1001, 4'hF, 1'b1, 3, 1'b1, 4'b1000, 1'b1);
        add(1'b0, 4'b1001, 4'hF, 1'b1, 3, 1'b1, 4'b1000, 1'b1);
        // output stall on 0 with 2 also valid
        for (int c = 0; c < 5; c++)
            add(1'b0, 4'b0101, 4'hF, 1'b0, 0, 1'b1, 4'h0, 1'b0);
        // enable withdrawn on the selected input
        add(1'b0, 4'b0001, 4'b1110, 1'b1, 0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 4'b0101, 4'hF, 1'b1, 0, 1'b1, 4'b0001, 1'b0);
        add(1'b0, 4'b0101, 4'hF, 1'b1, 0, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b0101, 4'hF, 1'b1, 0, 1'b1, 4'b0001, 1'b1);
        // en=1011 skips 2; re-enabled 2 served at its turn
        bursts_e = '{1, 3, 0, 1, 2};
        for (int b = 0; b < 5; b++) begin
            en_e = (b < 3) ? 4'b1011 : 4'b1111;
            for (int k = 0; k < 3; k++)
                add(1'b0, 4'hF, en_e, 1'b1, bursts_e[b], 1'b1, 4'(1 << bursts_e[b]), k != 0);
        end
        // reset mid-burst (g=3, cnt=2), restart from input 0
        add(1'b0, 4'hF, 4'hF, 1'b1, 3, 1'b1, 4'b1000, 1'b0);
        add(1'b0, 4'hF, 4'hF, 1'b1, 3, 1'b1, 4'b1000, 1'b1);
        add(1'b1, 4'hF, 4'hF, 1'b1, 0, 1'b0, 4'h0, 1'b0);
        add(1'b1, 4'hF, 4'hF, 1'b1, 0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 4'hF, 4'hF, 1'b1, 0, 1'b1, 4'b0001, 1'b0);
        add(1'b0, 4'hF, 4'hF, 1'b1, 0, 1'b1, 4'b0001, 1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset = vq[i].rst;
            in_v  = vq[i].v;
            en    = vq[i].e;
            out_a = vq[i].a;
            for (int ch = 0; ch < M; ch++)
                in_d[ch*N +: N] = dat(ch, i);
            #1;
            nvec++;
            if (out_v !== vq[i].ov) begin
                nerr++;
                $display("FAIL out_v vec %0d: got %b want %b", i, out_v, vq[i].ov);
            end
            if (in_a !== vq[i].ia) begin
                nerr++;
                $display("FAIL in_a vec %0d: got %b want %b", i, in_a, vq[i].ia);
            end
            if (locked !== vq[i].lk) begin
                nerr++;
                $display("FAIL locked vec %0d: got %b want %b", i, locked, vq[i].lk);
            end
            if (!vq[i].rst && (sel !== SW'(vq[i].sel))) begin
                nerr++;
                $display("FAIL sel vec %0d: got %0d want %0d", i, sel, vq[i].sel);
            end
            exp_d = dat(vq[i].sel, i);
            if (vq[i].ov && (out_d !== exp_d)) begin
                nerr++;
                $display("FAIL out_d vec %0d: got %h want %h", i, out_d, exp_d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/channel_rr_arbiter.md
Name: channel_rr_arbiter

Overview:
- M-way fair arbiter that shares one valid/data-acknowledge output channel between M requesting channels.
- Round-robin selection with burst locking: a granted input keeps the output for up to MaxBurst consecutive transfers while it stays valid, so multi-word packets stay contiguous and bursts are amortised.
- Generalises the two-input merge; sits in front of shared downstream resources such as the FPGA-to-core packet path.
- Per-input enable mask lets a controller park requesters without touching their handshake.

Parameters:
- N, 8: data width per channel.
- M, 4: number of input channels, ≥2.
- MaxBurst, 4: maximum consecutive transfers per grant, ≥1.
- SelW, $clog2(M): width of the selection index.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  asynchronous, active-high.
- in_d  input  M*N  input data, channel i at bits [i*N +: N].
- in_v  input  M  input valid.
- in_a  output  M  input acknowledge (combinational).
- en  input  M  per-input enable; disabled inputs are never selected.
- out_d  output  N  output data.
- out_v  output  1  output valid (combinational).
- out_a  input  1  output acknowledge (combinational from sink).
- sel  output  SelW  index currently driving out_d; meaningful only when out_v=1.
- locked  output  1  registered; high while a burst grant is held.

Behaviour:
- Reset clock and polarity: reset reset, asynchronous, active-high; clock clk.
- State registers: ptr (SelW, round-robin start), g (SelW, granted index), cnt (transfers in current burst, $clog2(MaxBurst+1) bits), locked.
- Reset values: ptr=0, g=0, cnt=0, locked=0. While reset=1: out_v=0 and in_a=0 regardless of inputs. sel=0 is permitted during reset.
- Request vector: req[i] = in_v[i] & en[i].
- Selection (combinational):
  - HOLD: locked=1 and req[g]=1 selects g.
  - Otherwise select the first i with req[i]=1, scanning ptr, ptr+1, …, M-1, 0, …, ptr-1 (modulo M).
  - If no request, out_v=0 and sel holds its last value.
- out_v = |req; out_d = in_d[sel]; in_a[sel] = out_v & out_a. All other in_a bits are 0.
- Zero latency: a transfer completes in the same cycle that out_v & out_a are high.
- Transfer is xfer = out_v & out_a. Register update on posedge:
  - xfer in HOLD, cnt+1 < MaxBurst: cnt<=cnt+1, locked stays 1.
  - xfer in HOLD, cnt+1 == MaxBurst: locked<=0, cnt<=0, ptr<=(g+1) mod M.
  - xfer on a new grant with MaxBurst>1: g<=sel, cnt<=1, locked<=1.
  - xfer on a new grant with MaxBurst==1: locked<=0, cnt<=0, ptr<=(sel+1) mod M.
  - locked=1 and req[g]=0 (source idles or is disabled mid-burst): the lock is broken that cycle. Selection falls to round-robin from ptr. On the edge: locked<=0, cnt<=0, ptr<=(g+1) mod M, unless the same edge takes a new-grant xfer, which has priority.
  - No xfer and no broken lock: state holds.
- Fairness: with all inputs permanently requesting, each input receives exactly MaxBurst consecutive transfers in order 0,1,…,M-1,0,…
- Output stall: when out_a=0, sel must not change while req[sel] stays high and no higher-priority lock appears. Data on out is stable until acked. Exception: a new request inserted earlier in scan order before a lock forms may reselect (same as the two-input merge).
- en deassertion on a selected input withdraws out_v combinationally. The source channel is never acked in that case.
- ptr wrap: (M-1)+1 wraps to 0. Non-power-of-2 M must wrap correctly; index values ≥M are never produced.
- Reset mid-burst: all state clears immediately and arbitration restarts from input 0.

Test Plan:
- M=4, MaxBurst=3, all in_v=1, en=1111, out_a=1 for 24 cycles -> sel sequence 0,0,0,1,1,1,2,2,2,3,3,3 repeating; locked high on cycles 2-3 of each burst.
- Only input 2 valid, out_a=1 for 10 cycles -> 10 transfers from input 2, cnt wraps every 3, ptr toggles to 3 but sel stays 2; no gaps in out_v.
- Input 1 granted (cnt=1), drops in_v while inputs 0 and 3 request -> same cycle sel=3 (scan from ptr=…), next state ptr=2 then serves 3; no ack ever reaches input 1 that cycle.
- out_a=0 for 5 cycles with inputs 0 and 2 valid -> out_d = in_d[0] stable, in_a=0000, state unchanged; on out_a=1, exactly one ack to input 0.
- en=1011 with all valid -> input 2 never selected or acked; order 0×3,1×3,3×3; set en[2]=1 mid-run -> 2 is served at its next round-robin turn.
- Assert reset during a burst (cnt=2, g=3) -> out_v=0 and in_a=0 immediately; after release, first grant goes to input 0 with cnt=1.
